multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives the same datapath control fields per phase.
- Adds instruction- and data-memory ready handshakes, a memory timeout, HALT, sticky error flags and a retired-instruction counter.

Parameters:
- OPCODE_W, 6: opcode width. Opcodes are compared zero-extended.
- HALT_OP, 6'b111111: opcode that enters HALT.
- TIMEOUT_W, 4: data-memory wait counter width. Timeout fires after 2^TIMEOUT_W-1 wait cycles.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPCODE_W  from the instruction register; valid in DECODE
- imem_ready  in  1  instruction fetch complete
- dmem_ready  in  1  data access complete
- state  out  3  RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
- imem_rd  out  1  fetch request
- ir_write  out  1  load the instruction register
- pc_write  out  1  PC+4 update
- alu_src  out  1  datapath field
- alu_op  out  3  datapath field
- branch  out  2  datapath field
- mem_read  out  1  datapath field
- mem_write  out  1  datapath field
- mem_to_reg  out  2  datapath field
- reg_write  out  2  datapath field
- illegal  out  1  sticky: undefined opcode seen
- mem_timeout  out  1  sticky: data access abandoned
- halted  out  1  state==HALT
- retired  out  CNT_W  instructions completed; wraps modulo 2^CNT_W

Behaviour:
- Reset: asynchronous, active-high. State=RST; op_q, wait counter, retired, illegal and mem_timeout cleared.
- All outputs are a pure function of state and op_q (no opcode-to-output combinational path); all outputs 0 in RST.
- RST -> FETCH unconditionally on the next edge.
- FETCH:
  - imem_rd=1.
  - imem_ready=0: stay in FETCH.
  - imem_ready=1: ir_write=1 and pc_write=1 in that same cycle; next state DECODE.
- DECODE:
  - op_q <= opcode.
  - opcode==HALT_OP: go to HALT.
  - opcode outside the classes below: set illegal, go to FETCH, no retire.
  - Otherwise go to EXEC.
- Classes, as alu_src/alu_op/branch/mem_to_reg/reg_write (the EXEC/MEM/WB values):
  - 0x00: 1/001/00/00/10. ALU-imm.
  - 0x01: 1/010/00/00/10. ALU-imm.
  - 0x02: 1/011/00/00/10. ALU-imm.
  - 0x03: 1/000/01/00/00. Branch.
  - 0x04: 1/000/10/00/00. Branch.
  - 0x05: 0/100/00/01/10, mem_read. Load.
  - 0x06: 0/101/00/00/00, mem_write. Store.
  - 0x07: 0/110/00/00/10. ALU-reg.
  - 0x08: 0/111/00/00/01. ALU-reg.
  - 0x09: 1/000/11/10/01. Call.
- EXEC:
  - alu_src and alu_op driven; branch driven for branch and call classes only.
  - Branch: go to FETCH, retire.
  - Load/store: go to MEM, clear the wait counter.
  - ALU/call: go to WB.
- MEM:
  - alu_src/alu_op held; mem_read (load) or mem_write (store) held until dmem_ready=1.
  - Load: go to WB.
  - Store: go to FETCH, retire.
  - Each cycle with dmem_ready=0, the wait counter increments. When it reaches all-ones and dmem_ready=0: set mem_timeout, go to FETCH, no retire, no WB.
  - dmem_ready=1 on the timeout cycle wins (normal completion).
- WB:
  - reg_write and mem_to_reg driven for exactly one cycle.
  - Go to FETCH, retire.
- HALT:
  - All control outputs 0, halted=1.
  - Left only by rst.
- Per-instruction latency with zero wait states:
  - Branch: 3 cycles.
  - ALU/call: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Fetch and memory wait cycles add 1:1.
- Retire: retired increments in the cycle the FSM leaves the completing state; all-ones wraps to 0.
- Reset asserted mid-instruction aborts immediately with no write strobe in the next cycle.

Test Plan:
- Reset, hold imem_ready=0 for 3 cycles -> RST one cycle then FETCH; imem_rd=1 for 3 cycles, ir_write=0; on imem_ready=1, ir_write=pc_write=1 for exactly one cycle.
- Opcode 0x05, dmem_ready=1 in MEM cycle 3 -> states 1,2,3,4,4,4,5; mem_read=1 across the MEM cycles; WB shows mem_to_reg=01, reg_write=10; retired=1.
- Opcode 0x03 with instant ready -> FETCH, DECODE, EXEC with branch=01 then FETCH; no WB; retired increments.
- Opcode 0x06, dmem_ready held 0, TIMEOUT_W=4 -> mem_write high 15 cycles, then mem_timeout=1, state FETCH, retired unchanged.
- Opcode 0x2A then HALT_OP -> illegal=1 and return to FETCH; then state=6, halted=1 held 20 cycles; rst clears everything.
- CNT_W=4, 16 back-to-back ALU ops (0x07) -> retired wraps 15->0; rst asserted mid-WB -> reg_write low on the next sample, state RST.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory handshakes, data-access timeout, HALT, sticky error flags and a retire counter.
module multicycle_control #(
  parameter int                    OPCODE_W  = 6,
  parameter logic [OPCODE_W-1:0]   HALT_OP   = OPCODE_W'(6'b111111),
  parameter int                    TIMEOUT_W = 4,
  parameter int                    CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic [2:0]          state,
  output logic                imem_rd,
  output logic                ir_write,
  output logic                pc_write,
  output logic                alu_src,
  output logic [2:0]          alu_op,
  output logic [1:0]          branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          reg_write,
  output logic                illegal,
  output logic                mem_timeout,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_BRANCH, K_LOAD, K_STORE, K_CALL, K_ILLEGAL
  } kind_t;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] branch;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_write;
  } fields_t;

  // Last wait count before the counter reaches all-ones; abandoning here gives
  // exactly 2^TIMEOUT_W-1 wait cycles.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  function automatic kind_t classify(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_W'(0), OPCODE_W'(1), OPCODE_W'(2),
      OPCODE_W'(7), OPCODE_W'(8): classify = K_ALU;
      OPCODE_W'(3), OPCODE_W'(4): classify = K_BRANCH;
      OPCODE_W'(5):               classify = K_LOAD;
      OPCODE_W'(6):               classify = K_STORE;
      OPCODE_W'(9):               classify = K_CALL;
      default:                    classify = K_ILLEGAL;
    endcase
  endfunction

  function automatic fields_t fields(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_W'(0): fields = '{1'b1, 3'b001, 2'b00, 2'b00, 2'b10};
      OPCODE_W'(1): fields = '{1'b1, 3'b010, 2'b00, 2'b00, 2'b10};
      OPCODE_W'(2): fields = '{1'b1, 3'b011, 2'b00, 2'b00, 2'b10};
      OPCODE_W'(3): fields = '{1'b1, 3'b000, 2'b01, 2'b00, 2'b00};
      OPCODE_W'(4): fields = '{1'b1, 3'b000, 2'b10, 2'b00, 2'b00};
      OPCODE_W'(5): fields = '{1'b0, 3'b100, 2'b00, 2'b01, 2'b10};
      OPCODE_W'(6): fields = '{1'b0, 3'b101, 2'b00, 2'b00, 2'b00};
      OPCODE_W'(7): fields = '{1'b0, 3'b110, 2'b00, 2'b00, 2'b10};
      OPCODE_W'(8): fields = '{1'b0, 3'b111, 2'b00, 2'b00, 2'b01};
      OPCODE_W'(9): fields = '{1'b1, 3'b000, 2'b11, 2'b10, 2'b01};
      default:      fields = '0;
    endcase
  endfunction

  state_t                state_q;
  logic [OPCODE_W-1:0]   op_q;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  kind_t                 kind_in, kind_q;
  fields_t               f_q;

  assign kind_in = classify(opcode);
  assign kind_q  = classify(op_q);
  assign f_q     = fields(op_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST;
      op_q        <= '0;
      wait_cnt    <= '0;
      retired     <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      case (state_q)
        S_RST:   state_q <= S_FETCH;
        S_FETCH: if (imem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          if (opcode == HALT_OP) begin
            state_q <= S_HALT;
          end else if (kind_in == K_ILLEGAL) begin
            illegal <= 1'b1;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (kind_q)
            K_BRANCH: begin
              state_q <= S_FETCH;
              retired <= retired + 1'b1;
            end
            K_LOAD, K_STORE: begin
              state_q  <= S_MEM;
              wait_cnt <= '0;
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (kind_q == K_LOAD) begin
              state_q <= S_WB;
            end else begin
              state_q <= S_FETCH;
              retired <= retired + 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              mem_timeout <= 1'b1;
              state_q     <= S_FETCH;
            end
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          retired <= retired + 1'b1;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RST;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    imem_rd    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    branch     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 2'b00;
    reg_write  = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_rd  = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EXEC: begin
        alu_src = f_q.alu_src;
        alu_op  = f_q.alu_op;
        if (kind_q == K_BRANCH || kind_q == K_CALL) branch = f_q.branch;
      end
      S_MEM: begin
        alu_src   = f_q.alu_src;
        alu_op    = f_q.alu_op;
        mem_read  = (kind_q == K_LOAD);
        mem_write = (kind_q == K_STORE);
      end
      S_WB: begin
        mem_to_reg = f_q.mem_to_reg;
        reg_write  = f_q.reg_write;
      end
      default: ;
    endcase
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, load, branch, store timeout,
// illegal/HALT and retire-counter wrap with reset mid-writeback.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       imem_ready, dmem_ready;
  logic [2:0] state;
  logic       imem_rd, ir_write, pc_write, alu_src;
  logic [2:0] alu_op;
  logic [1:0] branch;
  logic       mem_read, mem_write;
  logic [1:0] mem_to_reg, reg_write;
  logic       illegal, mem_timeout, halted;
  logic [3:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .HALT_OP(6'b111111), .TIMEOUT_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .state(state), .imem_rd(imem_rd), .ir_write(ir_write), .pc_write(pc_write),
    .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .mem_timeout(mem_timeout), .halted(halted), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply this cycle's inputs, let logic settle.
  task automatic step(input logic ir, input logic dr, input logic [5:0] op);
    @(negedge clk);
    imem_ready = ir;
    dmem_ready = dr;
    opcode     = op;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0;

    // Reset state
    step(0, 0, 0);
    check("rst_state", state, 0);
    check("rst_imem_rd", imem_rd, 0);
    check("rst_retired", retired, 0);
    check("rst_flags", {illegal, mem_timeout, halted}, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_release_state", state, 0);

    // Fetch stall for 3 cycles, then handshake
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("fetch_wait_state", state, 1);
      check("fetch_wait_imem_rd", imem_rd, 1);
      check("fetch_wait_ir_write", {ir_write, pc_write}, 0);
    end
    step(1, 0, 0);
    check("fetch_hs_state", state, 1);
    check("fetch_hs_ir_pc", {ir_write, pc_write}, 2'b11);

    // Load 0x05 with dmem_ready in the third MEM cycle
    step(0, 0, 6'h05);
    check("ld_decode", state, 2);
    check("ld_decode_ir_pc", {ir_write, pc_write}, 0);
    step(0, 0, 0);
    check("ld_exec", state, 3);
    check("ld_exec_alu", {alu_src, alu_op}, 4'b0100);
    check("ld_exec_mem_read", mem_read, 0);
    step(0, 0, 0);
    check("ld_mem1", {state, mem_read}, {3'd4, 1'b1});
    step(0, 0, 0);
    check("ld_mem2", {state, mem_read}, {3'd4, 1'b1});
    step(0, 1, 0);
    check("ld_mem3", {state, mem_read, alu_op}, {3'd4, 1'b1, 3'b100});
    step(0, 0, 0);
    check("ld_wb_state", state, 5);
    check("ld_wb_fields", {mem_to_reg, reg_write}, 4'b0110);
    check("ld_wb_mem_read", mem_read, 0);
    step(0, 0, 0);
    check("ld_done_state", state, 1);
    check("ld_retired", retired, 1);
    check("ld_done_reg_write", reg_write, 0);

    // Branch 0x03: FETCH, DECODE, EXEC then FETCH
    step(1, 0, 0);
    check("br_fetch", state, 1);
    step(0, 0, 6'h03);
    check("br_decode", state, 2);
    step(0, 0, 0);
    check("br_exec", {state, branch, alu_src, alu_op}, {3'd3, 2'b01, 1'b1, 3'b000});
    step(0, 0, 0);
    check("br_done", {state, branch, reg_write}, {3'd1, 2'b00, 2'b00});
    check("br_retired", retired, 2);

    // Store 0x06 with dmem_ready stuck low -> timeout after 15 wait cycles
    step(1, 0, 0);
    step(0, 0, 6'h06);
    step(0, 0, 0);
    check("st_exec", {state, mem_write, alu_op}, {3'd3, 1'b0, 3'b101});
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0);
      check("st_wait", {state, mem_write, mem_timeout}, {3'd4, 1'b1, 1'b0});
    end
    step(0, 0, 0);
    check("st_timeout", {state, mem_write, mem_timeout}, {3'd1, 1'b0, 1'b1});
    check("st_timeout_retired", retired, 2);

    // Illegal 0x2A, then HALT
    step(1, 0, 0);
    step(0, 0, 6'h2A);
    check("ill_decode", {state, illegal}, {3'd2, 1'b0});
    step(0, 0, 0);
    check("ill_done", {state, illegal}, {3'd1, 1'b1});
    check("ill_retired", retired, 2);
    step(1, 0, 0);
    step(0, 0, 6'h3F);
    check("halt_decode", state, 2);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0);
      check("halt_hold", {state, halted}, {3'd6, 1'b1});
      check("halt_outputs", {imem_rd, ir_write, pc_write, alu_src, alu_op, branch,
                             mem_read, mem_write, mem_to_reg, reg_write}, 0);
    end
    @(negedge clk); rst = 1'b1; #1;
    check("halt_rst_state", {state, halted}, 0);
    check("halt_rst_flags", {illegal, mem_timeout, retired}, 0);
    @(negedge clk); rst = 1'b0; #1;

    // 16 back-to-back ALU-reg ops (0x07): retired wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_ret;
      exp_ret = 4'(i);
      step(1, 0, 0);
      check("alu_fetch", {state, retired}, {3'd1, exp_ret});
      step(0, 0, 6'h07);
      step(0, 0, 0);
      check("alu_exec", {state, alu_src, alu_op}, {3'd3, 1'b0, 3'b110});
      step(0, 0, 0);
      check("alu_wb", {state, reg_write, mem_to_reg}, {3'd5, 2'b10, 2'b00});
    end
    step(1, 0, 0);
    check("wrap_retired", {state, retired}, {3'd1, 4'd0});
    step(0, 0, 6'h07);
    step(0, 0, 0);
    step(0, 0, 0);
    check("midwb_wb", {state, reg_write}, {3'd5, 2'b10});
    rst = 1'b1; #1;
    check("midwb_rst_state", state, 0);
    check("midwb_rst_reg_write", reg_write, 0);
    step(0, 0, 0);
    check("midwb_rst_hold", {state, reg_write, retired}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
